move_scheduler: RTL
===================

MOVE_SCHEDULER -- requirements
Module: move_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 1666666: clk cycles per move frame; legal range is at least 16.
REQ-002 Parameter STEP, default 1: pixels moved per actor per frame.
REQ-003 Parameter X_MAX, default 639, and Y_MAX, default 479: largest legal coordinates.
REQ-004 Parameter ACK_TIMEOUT, default 255: maximum cycles to wait for a wall-lookup ack.
REQ-005 clk  input  1  system clock.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 restart  input  1  synchronous level-sampled game restart.
REQ-008 actor_en  input  5  per-actor move enable; index 0=Pac-Man, 1=Blinky, 2=Pinky, 3=Inky, 4=Clyde.
REQ-009 actor_dir  input  15  3-bit direction per actor, with actor i in bits [3i+2:3i]; codes are 0 stop, 1 up, 2 down, 3 left, 4 right, and 5-7 are treated as stop.
REQ-010 wq_req  output  1  wall-lookup request.
REQ-011 wq_x, wq_y  output  16 each  candidate coordinate under lookup.
REQ-012 wq_ack  input  1  one-cycle lookup response.
REQ-013 wq_blocked  input  1  candidate is a wall; valid only with wq_ack.
REQ-014 pos_x, pos_y  output  80 each  actor positions, 16 bits per actor, with actor i in bits [16i+15:16i].
REQ-015 frame_done  output  1  one-cycle pulse at the end of each frame.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err_overrun, err_timeout  output  1 each  sticky error flags.

Function
REQ-018 Tick counter runs 0..TICK_DIV-1 and wraps; a tick is generated in the cycle the counter equals TICK_DIV-1.
REQ-019 FSM states: IDLE, SELECT, REQ, NEXT, DONE.
REQ-020 IDLE + tick: snapshot actor_en and actor_dir, set idx=0, go to SELECT.
REQ-021 SELECT, actor skip: actor idx is skipped (go to NEXT, no lookup) if disabled, its direction is stop, or its candidate lies outside 0..X_MAX / 0..Y_MAX.
REQ-022 SELECT, actor move: otherwise latch the candidate (pos ± STEP on one axis; up decrements y) and go to REQ.
REQ-023 Out-of-range test is done in 17-bit arithmetic, so x=0 moving left counts as out of range, not as a wrap to 65535.
REQ-024 REQ: hold wq_req=1 and wq_x/wq_y stable until wq_ack is sampled high; an ack while wq_req=0 is ignored.
REQ-025 On ack with wq_blocked=0, the candidate is written to actor idx, visible on pos_* the next cycle; with wq_blocked=1 the position is unchanged; either way go to NEXT.
REQ-026 If no ack arrives within ACK_TIMEOUT cycles in REQ: drop wq_req, leave position unchanged, set err_timeout, go to NEXT.
REQ-027 NEXT: if idx=4 go to DONE; otherwise increment idx and go to SELECT.
REQ-028 DONE: pulse frame_done for one cycle, return to IDLE.
REQ-029 Actors are serviced strictly in index order, at most one lookup each per frame.
REQ-030 A tick arriving while not in IDLE is dropped and sets err_overrun.
REQ-031 restart=1 has highest priority in any state: the FSM goes to IDLE, wq_req drops that cycle, positions load start values, the tick counter and both error flags clear, and no frame_done pulse is produced.
REQ-032 Changes to actor_en or actor_dir mid-frame have no effect until the next snapshot.

Reset
REQ-033 On rst: FSM=IDLE, idx=0, tick counter=0, wq_req=0, wq_x=wq_y=0, frame_done=0, busy=0, err flags=0.
REQ-034 Reset/start positions (x,y): Pac-Man (312,368), Blinky (312,200), Pinky (280,232), Inky (312,232), Clyde (344,232).

Structure
REQ-035 Shared package game_pkg holds the direction codes, actor indices, actor count (5), and start coordinates, for use by this block and the renderer.
REQ-036 The tick counter is a sub-module named move_tick_div, parameterised by TICK_DIV, with a clear input driven by restart.

Verification
REQ-037 TICK_DIV=16, all actors enabled and moving right, responder acks after 2 cycles with blocked=0 -> after one frame every x is +1, exactly 5 wq_req handshakes occur, and frame_done pulses once.
REQ-038 Pac-Man moving up, responder returns blocked=1 -> pacman_y stays 368; all other actors stopped produce no requests.
REQ-039 Force Pac-Man to x=0 moving left -> no wq_req for actor 0 and x stays 0; force x=639 moving right -> same.
REQ-040 Responder never acks, ACK_TIMEOUT=4 -> each request lasts 4 cycles, err_timeout=1, positions unchanged, frame completes.
REQ-041 Responder delays ack beyond TICK_DIV -> err_overrun=1 and the next frame starts only after DONE.
REQ-042 Assert restart while in REQ -> wq_req=0 the next cycle, all positions equal start values, errors clear; and assert rst asynchronously mid-frame -> same values immediately.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: direction codes, actor indices, start positions.
// Used by the move scheduler and the renderer.
package game_pkg;

  localparam int N_ACTORS = 5;

  typedef enum logic [2:0] {
    DIR_STOP  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

  localparam int ACT_PACMAN = 0;
  localparam int ACT_BLINKY = 1;
  localparam int ACT_PINKY  = 2;
  localparam int ACT_INKY   = 3;
  localparam int ACT_CLYDE  = 4;

  // Actor 0 in the low 16 bits.
  localparam logic [79:0] START_X = {
    16'd344, 16'd312, 16'd280, 16'd312, 16'd312
  };
  localparam logic [79:0] START_Y = {
    16'd232, 16'd232, 16'd232, 16'd200, 16'd368
  };

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_NEXT,
    S_DONE
  } ms_state_e;

endpackage

// File: rtl/move_tick_div.sv
// Frame tick divider: counts 0..TICK_DIV-1, o_tick on the last count.
// Ports: clk, rst (async high), i_clr (sync clear), o_tick.
module move_tick_div #(
  parameter int TICK_DIV = 1666666
)(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/move_scheduler.sv
// Per-frame actor mover: one wall lookup per moving actor, in index order.
// Ports: clk/rst/restart, actor_en/dir, wq_* lookup, pos_*, status flags.
module move_scheduler
  import game_pkg::*;
#(
  parameter int TICK_DIV    = 1666666,
  parameter int STEP        = 1,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int ACK_TIMEOUT = 255
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [4:0]  actor_en,
  input  logic [14:0] actor_dir,
  output logic        wq_req,
  output logic [15:0] wq_x,
  output logic [15:0] wq_y,
  input  logic        wq_ack,
  input  logic        wq_blocked,
  output logic [79:0] pos_x,
  output logic [79:0] pos_y,
  output logic        frame_done,
  output logic        busy,
  output logic        err_overrun,
  output logic        err_timeout
);

  localparam int WW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WW-1:0] W_LAST = WW'(ACK_TIMEOUT - 1);
  localparam logic [2:0] IDX_LAST = 3'(N_ACTORS - 1);
  localparam logic [16:0] STEP17 = 17'(STEP);
  localparam logic [16:0] XMAX17 = 17'(X_MAX);
  localparam logic [16:0] YMAX17 = 17'(Y_MAX);

  ms_state_e r_state;
  ms_state_e w_next;

  logic [2:0]              r_idx;
  logic [4:0]              r_en;
  logic [14:0]             r_dir;
  logic [15:0]             r_wq_x;
  logic [15:0]             r_wq_y;
  logic [WW-1:0]           r_wait;
  logic [N_ACTORS-1:0][15:0] r_px;
  logic [N_ACTORS-1:0][15:0] r_py;
  logic                    r_ovr;
  logic                    r_tmo;

  logic        w_tick;
  logic [2:0]  w_dir;
  logic [16:0] w_cx;
  logic [16:0] w_cy;
  logic        w_go;
  logic        w_move;
  logic        w_to;

  move_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .i_clr (restart),
    .o_tick(w_tick)
  );

  assign w_dir = r_dir[r_idx*3 +: 3];

  // 17-bit candidate: a step below zero wraps far above any *_MAX.
  always_comb begin
    w_cx = {1'b0, r_px[r_idx]};
    w_cy = {1'b0, r_py[r_idx]};
    w_go = 1'b1;
    case (w_dir)
      DIR_UP:    w_cy = {1'b0, r_py[r_idx]} - STEP17;
      DIR_DOWN:  w_cy = {1'b0, r_py[r_idx]} + STEP17;
      DIR_LEFT:  w_cx = {1'b0, r_px[r_idx]} - STEP17;
      DIR_RIGHT: w_cx = {1'b0, r_px[r_idx]} + STEP17;
      default:   w_go = 1'b0;
    endcase
  end

  assign w_move = r_en[r_idx] && w_go &&
                  (w_cx <= XMAX17) && (w_cy <= YMAX17);

  // Ack in the final wait cycle still counts as an ack.
  assign w_to = (r_wait == W_LAST) && !wq_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_tick) w_next = S_SELECT;
      S_SELECT: w_next = w_move ? S_REQ : S_NEXT;
      S_REQ:    if (wq_ack || w_to) w_next = S_NEXT;
      S_NEXT:   w_next = (r_idx == IDX_LAST) ? S_DONE : S_SELECT;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (restart) w_next = S_IDLE;
  end

  always_comb begin
    wq_req     = (r_state == S_REQ) && !restart;
    frame_done = (r_state == S_DONE) && !restart;
    busy       = (r_state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_en   <= '0;
      r_dir  <= '0;
      r_wq_x <= '0;
      r_wq_y <= '0;
      r_wait <= '0;
      r_px   <= START_X;
      r_py   <= START_Y;
      r_ovr  <= 1'b0;
      r_tmo  <= 1'b0;
    end else if (restart) begin
      r_idx  <= '0;
      r_wait <= '0;
      r_px   <= START_X;
      r_py   <= START_Y;
      r_ovr  <= 1'b0;
      r_tmo  <= 1'b0;
    end else begin
      if (w_tick && r_state == S_IDLE) begin
        r_en  <= actor_en;
        r_dir <= actor_dir;
        r_idx <= '0;
      end
      if (w_tick && r_state != S_IDLE) begin
        r_ovr <= 1'b1;
      end
      if (r_state == S_SELECT && w_move) begin
        r_wq_x <= w_cx[15:0];
        r_wq_y <= w_cy[15:0];
      end
      if (r_state == S_REQ) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (r_state == S_REQ && wq_ack && !wq_blocked) begin
        r_px[r_idx] <= r_wq_x;
        r_py[r_idx] <= r_wq_y;
      end
      if (r_state == S_REQ && w_to) begin
        r_tmo <= 1'b1;
      end
      if (r_state == S_NEXT && r_idx != IDX_LAST) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign wq_x        = r_wq_x;
  assign wq_y        = r_wq_y;
  assign pos_x       = r_px;
  assign pos_y       = r_py;
  assign err_overrun = r_ovr;
  assign err_timeout = r_tmo;

endmodule
